exe_mult_unit: RTL and testbench

- Iterative shift-add multiplier in the EXE stage. Consumes the multiply command that ID decode issues as EXE_CMD_MULT with WB_EN=0.
- Writes the 2*WORD_LEN-bit product into architectural HI/LO registers, not into the register file.
- Asserts busy so the hazard unit freezes IF/ID/EXE while a multiply is in flight.
- Completion is signalled with a one-cycle done pulse.

---
 rtl/exe_mult_unit.sv | 109 ++++++++++
 tb/tb_exe_mult_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mult_unit.sv
// Iterative radix-2 shift-add multiplier for the EXE stage.
// Writes the full 2*WORD_LEN-bit product to HI/LO and stalls the pipeline while running.
module exe_mult_unit #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] src1,
  input  logic [WORD_LEN-1:0] src2,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo
);

  localparam int unsigned PROD_W = 2 * WORD_LEN;
  localparam bit          SGN_EN = (SIGNED != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [PROD_W-1:0]     r_acc;
  logic [PROD_W-1:0]     r_mcand;
  logic [WORD_LEN-1:0]   r_mplier;
  logic                  r_neg;
  logic                  r_done;
  logic [WORD_LEN-1:0]   r_hi;
  logic [WORD_LEN-1:0]   r_lo;

  logic [WORD_LEN-1:0]   w_mag1;
  logic [WORD_LEN-1:0]   w_mag2;
  logic                  w_neg;
  logic                  w_start_ok;
  logic [PROD_W-1:0]     w_acc_next;
  logic [PROD_W-1:0]     w_result;

  // Magnitudes stay unsigned in WORD_LEN bits, so the most-negative value maps to 2^(WORD_LEN-1) exactly.
  assign w_mag1     = (SGN_EN && src1[WORD_LEN-1]) ? -src1 : src1;
  assign w_mag2     = (SGN_EN && src2[WORD_LEN-1]) ? -src2 : src2;
  assign w_neg      = SGN_EN & (src1[WORD_LEN-1] ^ src2[WORD_LEN-1]);
  assign w_start_ok = start & ~flush;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_result   = r_neg ? -r_acc : r_acc;

  assign busy = ((r_state == S_IDLE) & w_start_ok) | (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state  <= S_RUN;
            r_mcand  <= {{WORD_LEN{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_neg    <= w_neg;
            r_cnt    <= '0;
            r_acc    <= '0;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WORD_LEN - 1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Commit the sign-corrected product; flush and start are ignored here.
          {r_hi, r_lo} <= w_result;
          r_done       <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mult_unit.sv
// Randomized self-checking bench for exe_mult_unit against an arithmetic product model.
module tb_exe_mult_unit;

  localparam int unsigned WORD_LEN = 32;
  localparam int unsigned SIGNED   = 1;

  logic                clk;
  logic                rst;
  logic                start;
  logic                flush;
  logic [WORD_LEN-1:0] src1;
  logic [WORD_LEN-1:0] src2;
  logic                busy;
  logic                done;
  logic [WORD_LEN-1:0] hi;
  logic [WORD_LEN-1:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_hilo = '0;

  exe_mult_unit #(
    .WORD_LEN(WORD_LEN),
    .SIGNED  (SIGNED),
    .CNT_W   (6)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .flush(flush),
    .src1 (src1),
    .src2 (src2),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (SIGNED != 0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs with start idle and verifies no done pulse and HI/LO unchanged.
  task automatic quiet_window(input string tag, input int cycles);
    int n_done = 0;
    start = 1'b0;
    flush = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (done) n_done++;
    end
    check({tag, "_no_done"}, 64'(n_done), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp_hilo);
  endtask

  // One multiply with start held for 'hold' cycles; observes a 40-cycle window.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int hold);
    int          busy_cycles = 0;
    int          first_done  = -1;
    int          n_done      = 0;
    int          second_done = -1;
    logic [63:0] got         = '0;
    logic [63:0] exp;
    exp   = model(a, b);
    src1  = a;
    src2  = b;
    flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      start = (c < hold);
      #1;
      if (c <= 33 && busy) busy_cycles++;
      tick();
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = c;
          got        = {hi, lo};
        end
      end
    end
    start = 1'b0;
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    check("done_edge", 64'(first_done), 64'd33);
    check("done_count", 64'(n_done), 64'd1);
    check("product", got, exp);
    if (hold > 34) begin
      // A held start re-launches once the unit is back in IDLE, at edge 34.
      for (int c = 40; c < 80 && second_done < 0; c++) begin
        tick();
        if (done) second_done = c;
      end
      check("second_done_edge", 64'(second_done), 64'd67);
      check("second_product", {hi, lo}, exp);
    end
    exp_hilo = exp;
    check("hilo_hold", {hi, lo}, exp_hilo);
  endtask

  initial begin
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    int          n_done;

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    src1  = '0;
    src2  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    run_mult(32'd3, 32'd5, 1);
    run_mult(32'hFFFF_FFFE, 32'd3, 1);
    run_mult(32'h8000_0000, 32'h8000_0000, 1);

    // Flush at RUN cycle 10 discards the 9*9 and keeps 42.
    run_mult(32'd7, 32'd6, 1);
    src1  = 32'd9;
    src2  = 32'd9;
    start = 1'b1;
    tick();
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    #1;
    check("flush_busy_in_run", 64'(busy), 64'd1);
    tick();
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_busy_after", 64'(busy), 64'd0);
    quiet_window("flush", 40);

    // Synchronous reset at RUN cycle 20 aborts and clears HI/LO.
    src1  = 32'hFFFF_FFFF;
    src2  = 32'd2;
    start = 1'b1;
    tick();
    for (int k = 1; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    exp_hilo = '0;
    #1;
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_done", 64'(done), 64'd0);
    quiet_window("rst_run", 40);

    run_mult(32'hFFFF_FFFF, 32'd2, 40);

    // start and flush together in IDLE never launch.
    src1  = 32'd11;
    src2  = 32'd13;
    start = 1'b1;
    flush = 1'b1;
    #1;
    check("sf_busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("sf_busy_next", 64'(busy), 64'd0);
    quiet_window("sf", 36);

    for (int t = 0; t < 20; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'(int'($urandom_range(0, 15)));
        default: a = $urandom;
      endcase
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       b = 32'h8000_0000;
        1:       b = 32'd0;
        2:       b = 32'h7FFF_FFFF;
        default: b = $urandom;
      endcase
      run_mult(a, b, int'($urandom_range(1, 33)));
    end

    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done) n_done++;
    end
    check("final_idle_done", 64'(n_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
